ring_buffer_flex: RTL and testbench
===================================

Name: ring_buffer_flex

Overview:
- Parametrised successor ring buffer: set-wide FIFO, each entry is DATA_OF_SET words of DATA_WIDTH bits.
- Sits between the input/weight loaders and the convolution PE array as the set-staging buffer.
- Adds over the current buffer: occupancy count, programmable almost-full/almost-empty thresholds, defined simultaneous read/write at full and empty, registered dout with valid strobe, optional sticky error flags.

Parameters:
- DATA_WIDTH, 4, bits per word.
- DATA_OF_SET, 4, words per entry.
- BUFFER_SIZE, 4, entries. Power of two, >= 2.
- AFULL_TH, BUFFER_SIZE-1, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wen  in  1  write request.
- ren  in  1  read request.
- din  in  [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  write set.
- dout  out  [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  read set, registered.
- dout_valid  out  1  one-cycle pulse: dout was loaded at the last edge.
- full_flag  out  1  count == BUFFER_SIZE.
- empty_flag  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(BUFFER_SIZE)+1  current occupancy.
- wptr_check  out  $clog2(BUFFER_SIZE)  write pointer.
- rptr_check  out  $clog2(BUFFER_SIZE)  read pointer.
- err_clr  in  1  clears sticky error flags.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async assert, released synchronously by clk):
  - wptr, rptr, count = 0; dout = 0; dout_valid = 0; overflow = 0; underflow = 0.
  - empty_flag = 1, almost_empty = 1, full_flag = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored entries immediately; there is no drain.
- Acceptance rules, evaluated on pre-edge state:
  - wr_acc = wen & (!full_flag | ren).
  - rd_acc = ren & !empty_flag.
- Full, wen & ren: both accepted, count unchanged, the oldest entry is output.
- Empty, wen & ren: write accepted, read rejected. No bypass; underflow is set.
- Write: mem[wptr] <= din; wptr increments modulo BUFFER_SIZE (natural wrap).
- Read: dout <= mem[rptr]; rptr increments modulo BUFFER_SIZE; dout_valid = 1 the following cycle. Latency from ren to data is 1 cycle.
- dout holds its value when no read is accepted. dout_valid = 0 otherwise.
- count next value:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - unchanged when both or neither are accepted.
- All flags are decoded from the count register only; there is no combinational path from wen/ren to any output.
- Error flags:
  - Rejected write (wen & !wr_acc) sets overflow.
  - Rejected read (ren & !rd_acc) sets underflow.
  - err_clr clears both; a set event in the same cycle as err_clr wins.
- Rejected operations change no pointer, no count and no data.

Optional Feature:
- Macro: RING_BUFFER_FLEX_ERR_EN.
- Defined: overflow/underflow behave as above.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and the error logic is not synthesised. The port list is identical in both builds.

Test Plan:
- Reset then fill: 4 writes of sets 1,2,3,4 (all words equal) -> count 1,2,3,4; almost_full at count 3; full_flag at 4; wptr_check wraps to 0.
- Write while full with ren=0 (din=5) -> write rejected, count stays 4, overflow=1; err_clr pulse -> overflow=0.
- Full, wen=1 ren=1, din=6 -> dout=1 with dout_valid one cycle later; count stays 4; entry 6 is read after sets 2,3,4.
- Drain 4 reads -> dout 2,3,4,6 with dout_valid each cycle; empty_flag=1; rptr_check=wptr_check.
- Read while empty -> dout unchanged, dout_valid=0, underflow=1. Empty, wen=1 ren=1 din=7 -> count=1, no dout_valid, underflow=1.
- Assert rst asynchronously between edges at count 2 -> count=0, empty_flag=1, dout=0 immediately; next write/read returns the new data.

Source files
------------

// File: rtl/ring_buffer_flex_if.sv
// ring_buffer_flex_if: handshake and status bundle between the set loaders and the set-staging ring buffer.
interface ring_buffer_flex_if #(
   parameter int DATA_WIDTH  = 4,
   parameter int DATA_OF_SET = 4,
   parameter int BUFFER_SIZE = 4
);
   localparam int AW = $clog2(BUFFER_SIZE);
   logic wen, ren, err_clr;
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din, dout;
   logic dout_valid, full_flag, empty_flag, almost_full, almost_empty, overflow, underflow;
   logic [AW:0] count;
   logic [AW-1:0] wptr_check, rptr_check;
   modport master (
      output wen, ren, din, err_clr,
      input dout, dout_valid, full_flag, empty_flag, almost_full, almost_empty, count,
      wptr_check, rptr_check, overflow, underflow
   );
   modport slave (
      input wen, ren, din, err_clr,
      output dout, dout_valid, full_flag, empty_flag, almost_full, almost_empty, count,
      wptr_check, rptr_check, overflow, underflow
   );
endinterface

// File: rtl/ring_buffer_flex.sv
// ring_buffer_flex: set-wide FIFO with occupancy count, threshold flags and registered dout.
// Sticky overflow/underflow flags are built only when RING_BUFFER_FLEX_ERR_EN is defined.
module ring_buffer_flex #(
   parameter int DATA_WIDTH  = 4,
   parameter int DATA_OF_SET = 4,
   parameter int BUFFER_SIZE = 4,
   parameter int AFULL_TH    = BUFFER_SIZE - 1,
   parameter int AEMPTY_TH   = 1
) (
   input logic clk,
   input logic rst,
   ring_buffer_flex_if.slave bus
);
   localparam int AW = $clog2(BUFFER_SIZE);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(BUFFER_SIZE);
   localparam logic [AW:0] AF_CNT = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AE_CNT = (AW+1)'(AEMPTY_TH);
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] mem [BUFFER_SIZE];
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] cnt;
   logic dout_valid, full, empty, wr_acc, rd_acc;
   // Flags come from the count register alone, so no input reaches an output combinationally.
   assign full = cnt == FULL_CNT;
   assign empty = cnt == '0;
   assign wr_acc = bus.wen & (~full | bus.ren);
   assign rd_acc = bus.ren & ~empty;
   always_ff @(posedge clk)
      if (wr_acc) mem[wptr] <= bus.din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt <= '0;
         dout <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= rd_acc;
         if (rd_acc) begin
            dout <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         if (wr_acc) wptr <= wptr + 1'b1;
         if (wr_acc != rd_acc) cnt <= wr_acc ? cnt + 1'b1 : cnt - 1'b1;
      end
   assign bus.dout = dout;
   assign bus.dout_valid = dout_valid;
   assign bus.full_flag = full;
   assign bus.empty_flag = empty;
   assign bus.almost_full = cnt >= AF_CNT;
   assign bus.almost_empty = cnt <= AE_CNT;
   assign bus.count = cnt;
   assign bus.wptr_check = wptr;
   assign bus.rptr_check = rptr;
`ifdef RING_BUFFER_FLEX_ERR_EN
   logic ovf, udf;
   // A new rejection in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         ovf <= (bus.wen & ~wr_acc) | (ovf & ~bus.err_clr);
         udf <= (bus.ren & ~rd_acc) | (udf & ~bus.err_clr);
      end
   assign bus.overflow = ovf;
   assign bus.underflow = udf;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow = 1'b0;
   assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ring_buffer_flex.sv
// tb_ring_buffer_flex: directed plan plus random traffic against a queue-based reference model.
module tb_ring_buffer_flex;
   localparam int BS = 4;
   localparam int AF = BS - 1;
   localparam int AE = 1;
`ifdef RING_BUFFER_FLEX_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [15:0] q[$];
   logic [15:0] m_dout = '0;
   bit m_dv = 1'b0, m_ov = 1'b0, m_un = 1'b0;
   int m_w = 0, m_r = 0;

   ring_buffer_flex_if #(.DATA_WIDTH(4), .DATA_OF_SET(4), .BUFFER_SIZE(BS)) bus ();
   ring_buffer_flex #(.DATA_WIDTH(4), .DATA_OF_SET(4), .BUFFER_SIZE(BS), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] set_of(input logic [3:0] v);
      return {4{v}};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_dv = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
      m_w = 0;
      m_r = 0;
   endtask

   task automatic step(input bit w, input bit r, input logic [15:0] d, input bit c);
      bit wa, ra;
      bus.wen = w;
      bus.ren = r;
      bus.din = d;
      bus.err_clr = c;
      @(posedge clk);
      wa = w && (q.size() < BS || r);
      ra = r && q.size() > 0;
      m_dv = ra;
      if (ra) begin
         m_dout = q.pop_front();
         m_r = (m_r + 1) % BS;
      end
      if (wa) begin
         q.push_back(d);
         m_w = (m_w + 1) % BS;
      end
      m_ov = ERR && ((w && !wa) || (m_ov && !c));
      m_un = ERR && ((r && !ra) || (m_un && !c));
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      chk("count", 32'(bus.count), q.size());
      chk("full_flag", 32'(bus.full_flag), 32'(q.size() == BS));
      chk("empty_flag", 32'(bus.empty_flag), 32'(q.size() == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      chk("wptr", 32'(bus.wptr_check), m_w);
      chk("rptr", 32'(bus.rptr_check), m_r);
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
      chk("overflow", 32'(bus.overflow), 32'(m_ov));
      chk("underflow", 32'(bus.underflow), 32'(m_un));
   end

   initial begin
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      bus.din = '0;
      bus.err_clr = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty_flag), 1);
      chk("rst_aempty", 32'(bus.almost_empty), 1);
      chk("rst_full", 32'(bus.full_flag), 0);
      chk("rst_afull", 32'(bus.almost_full), 0);
      chk("rst_dout", 32'(bus.dout), 0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, set_of(4'(i)), 0);
         chk("fill_count", 32'(bus.count), i);
         chk("fill_afull", 32'(bus.almost_full), 32'(i >= 3));
      end
      chk("fill_full", 32'(bus.full_flag), 1);
      chk("fill_wptr_wrap", 32'(bus.wptr_check), 0);
      step(1, 0, set_of(4'd5), 0);
      chk("ovf_count", 32'(bus.count), 4);
      chk("ovf_flag", 32'(bus.overflow), 32'(ERR));
      step(0, 0, '0, 1);
      chk("ovf_clr", 32'(bus.overflow), 0);
      step(1, 1, set_of(4'd6), 0);
      chk("rw_full_dout", 32'(bus.dout), 32'h1111);
      chk("rw_full_valid", 32'(bus.dout_valid), 1);
      chk("rw_full_count", 32'(bus.count), 4);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, '0, 0);
         chk("drain_dout", 32'(bus.dout), i == 3 ? 32'h6666 : 32'(set_of(4'(i + 2))));
         chk("drain_valid", 32'(bus.dout_valid), 1);
      end
      chk("drain_empty", 32'(bus.empty_flag), 1);
      chk("drain_wptr", 32'(bus.wptr_check), 1);
      chk("drain_rptr", 32'(bus.rptr_check), 1);
      step(0, 1, '0, 0);
      chk("udf_dout_hold", 32'(bus.dout), 32'h6666);
      chk("udf_valid", 32'(bus.dout_valid), 0);
      chk("udf_flag", 32'(bus.underflow), 32'(ERR));
      step(1, 1, set_of(4'd7), 0);
      chk("empty_rw_count", 32'(bus.count), 1);
      chk("empty_rw_valid", 32'(bus.dout_valid), 0);
      chk("empty_rw_udf", 32'(bus.underflow), 32'(ERR));
      step(1, 0, set_of(4'd8), 0);
      chk("pre_rst_count", 32'(bus.count), 2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_count", 32'(bus.count), 0);
      chk("async_empty", 32'(bus.empty_flag), 1);
      chk("async_dout", 32'(bus.dout), 0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, set_of(4'd9), 0);
      step(0, 1, '0, 0);
      chk("post_rst_dout", 32'(bus.dout), 32'h9999);
      chk("post_rst_valid", 32'(bus.dout_valid), 1);
      for (int i = 0; i < 800; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 75 : 30;
         step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp,
              16'($urandom), $urandom_range(0, 15) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
